// File: rtl/writeback_unit.sv
// W-stage register: selects/extends the M-stage result and counts retirements.
// Latency 1 cycle; StallW holds every W register, FlushW (higher priority) loads a bubble.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int CNTW = 64,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [SELW-1:0] ResultSrcM,
  input  logic [4:0]      RdM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ResultW,
  output logic            LoadFaultW,
  output logic [CNTW-1:0] RetireCount
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            fault;
  } wb_t;

  wb_t             w_q;
  wb_t             w_d;
  logic [CNTW-1:0] retire_q;
  logic [1:0]      offset;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_dat;
  logic [XLEN-1:0] sel_dat;
  logic            is_load;
  logic            misaligned;
  logic            accept;
  int unsigned     sel_idx;

  assign offset  = ALUResultM[1:0];
  assign shifted = ReadDataM >> {offset, 3'b000};
  assign sel_idx = 32'(ResultSrcM);
  assign is_load = (sel_idx == 1) && (NSRC > 1);
  assign accept  = !StallW && !FlushW;

  always_comb begin
    load_dat = ReadDataM;
    case (Funct3M)
      3'b000:  load_dat = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_dat = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_dat = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_dat = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_dat = ReadDataM;
    endcase
  end

  // Halfword loads need an even offset, word loads need offset 0.
  always_comb begin
    misaligned = 1'b0;
    if (ValidM && is_load) begin
      if ((Funct3M == 3'b001 || Funct3M == 3'b101) && offset[0])
        misaligned = 1'b1;
      else if (Funct3M == 3'b010 && offset != 2'b00)
        misaligned = 1'b1;
    end
  end

  always_comb begin
    sel_dat = '0;
    if (sel_idx < NSRC) begin
      case (sel_idx)
        0:       sel_dat = ALUResultM;
        1:       sel_dat = load_dat;
        2:       sel_dat = PCPlus4M;
        3:       sel_dat = ImmExtM;
        default: sel_dat = '0;
      endcase
    end
  end

  always_comb begin
    w_d          = '0;
    w_d.valid    = ValidM;
    w_d.regwrite = RegWriteM && ValidM && (RdM != 5'd0) && !misaligned;
    w_d.rd       = RdM;
    w_d.result   = misaligned ? '0 : sel_dat;
    w_d.fault    = misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q      <= '0;
      retire_q <= '0;
    end else if (FlushW) begin
      w_q      <= '0;
    end else if (accept) begin
      w_q      <= w_d;
      if (ValidM && !misaligned)
        retire_q <= retire_q + 1'b1;
    end
  end

  assign ValidW      = w_q.valid;
  assign RegWriteW   = w_q.regwrite;
  assign RdW         = w_q.rd;
  assign ResultW     = w_q.result;
  assign LoadFaultW  = w_q.fault;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Random and directed stimulus for writeback_unit checked against a behavioural model.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
  logic        ValidW, RegWriteW, LoadFaultW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [7:0]  RetireCount;

  int vectors = 0;
  int miscompares = 0;

  // model of the W stage
  bit          m_valid, m_we, m_fault;
  int unsigned m_rd;
  logic [31:0] m_res;
  int unsigned m_cnt;

  writeback_unit #(.XLEN(32), .NSRC(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LoadFaultW(LoadFaultW), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input int unsigned f3, input longint unsigned data,
                                             input int unsigned off);
    longint unsigned sh = data / (longint'(1) << (8 * off));
    longint unsigned b  = sh % 256;
    longint unsigned h  = sh % 65536;
    case (f3)
      0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      4: return 32'(b);
      5: return 32'(h);
      default: return 32'(data);
    endcase
  endfunction

  function automatic bit fault_model();
    int unsigned off = ALUResultM % 4;
    if (!ValidM || ResultSrcM != 2'd1) return 0;
    if ((Funct3M == 3'd1 || Funct3M == 3'd5) && (off % 2 == 1)) return 1;
    if (Funct3M == 3'd2 && off != 0) return 1;
    return 0;
  endfunction

  task automatic model_clear(input bit with_cnt);
    m_valid = 0; m_we = 0; m_fault = 0; m_rd = 0; m_res = '0;
    if (with_cnt) m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(ValidW), 64'(m_valid));
    chk({tag, ".we"},    64'(RegWriteW), 64'(m_we));
    chk({tag, ".rd"},    64'(RdW), 64'(m_rd));
    chk({tag, ".res"},   64'(ResultW), 64'(m_res));
    chk({tag, ".fault"}, 64'(LoadFaultW), 64'(m_fault));
    chk({tag, ".cnt"},   64'(RetireCount), 64'(m_cnt));
  endtask

  // Advance one clock: update the model from the current inputs, then check #1 after the edge.
  task automatic step(input string tag);
    bit mis;
    if (rst) model_clear(1);
    else if (FlushW) model_clear(0);
    else if (!StallW) begin
      mis     = fault_model();
      m_valid = ValidM;
      m_fault = mis;
      m_rd    = RdM;
      m_we    = RegWriteM && ValidM && RdM != 0 && !mis;
      case (ResultSrcM)
        2'd0: m_res = ALUResultM;
        2'd1: m_res = load_model(Funct3M, ReadDataM, ALUResultM % 4);
        2'd2: m_res = PCPlus4M;
        default: m_res = ImmExtM;
      endcase
      if (mis) m_res = '0;
      if (ValidM && !mis) m_cnt = (m_cnt + 1) % 256;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_m(input bit v, input bit we, input logic [1:0] src, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] data);
    ValidM = v; RegWriteM = we; ResultSrcM = src; RdM = rd; Funct3M = f3;
    ALUResultM = alu; ReadDataM = data;
    PCPlus4M = $urandom; ImmExtM = $urandom;
  endtask

  task automatic randomize_m();
    set_m(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
          3'($urandom), $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; StallW = 0; FlushW = 0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // LB sign-extends the byte at offset 2
    set_m(1, 1, 2'd1, 5'd5, 3'b000, 32'h0000_1002, 32'h80FF_7F01);
    step("lb");
    chk("lb.const_res", 64'(ResultW), 64'hFFFF_FFFF);
    chk("lb.const_cnt", 64'(RetireCount), 64'd1);

    set_m(1, 1, 2'd1, 5'd6, 3'b101, 32'h0000_1002, 32'h80FF_7F01);
    step("lhu");
    chk("lhu.const_res", 64'(ResultW), 64'h0000_80FF);

    set_m(1, 1, 2'd1, 5'd7, 3'b010, 32'h0000_1001, 32'h80FF_7F01);
    step("lw_mis");
    chk("lw_mis.fault", 64'(LoadFaultW), 64'd1);
    chk("lw_mis.cnt", 64'(RetireCount), 64'd2);

    // Stall three cycles while M changes
    StallW = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_m();
      step("stall");
      chk("stall.const_fault", 64'(LoadFaultW), 64'd1);
    end
    FlushW = 1;
    step("flush_stall");
    chk("flush_stall.valid", 64'(ValidW), 64'd0);
    StallW = 0; FlushW = 0;

    set_m(1, 1, 2'd2, 5'd0, 3'b000, 32'h3, 32'h0);
    PCPlus4M = 32'h0000_0104;
    step("pc4_x0");
    chk("pc4_x0.const_res", 64'(ResultW), 64'h104);
    chk("pc4_x0.const_we", 64'(RegWriteW), 64'd0);

    // Random mix of stalls, flushes, sources and load codes
    for (int i = 0; i < 400; i++) begin
      StallW = ($urandom_range(0, 4) == 0);
      FlushW = ($urandom_range(0, 9) == 0);
      randomize_m();
      step("rand");
    end
    StallW = 0; FlushW = 0;

    // Async reset mid-stall, between edges
    set_m(1, 1, 2'd0, 5'd9, 3'b000, 32'hDEAD_BEEF, 32'h0);
    step("pre_rst");
    StallW = 1;
    #2 rst = 1'b1;
    #1;
    model_clear(1);
    check_all("async_rst");
    step("rst_held");
    rst = 1'b0; StallW = 0;
    set_m(1, 1, 2'd3, 5'd12, 3'b000, 32'h0, 32'h0);
    step("post_rst");
    chk("post_rst.const_cnt", 64'(RetireCount), 64'd1);

    // Counter wrap: reach 255, then one more accept
    while (m_cnt != 255) begin
      randomize_m();
      ValidM = 1; ResultSrcM = 2'd0;
      step("fill");
    end
    chk("cnt_max", 64'(RetireCount), 64'd255);
    set_m(1, 1, 2'd0, 5'd1, 3'b000, 32'h1, 32'h0);
    step("wrap");
    chk("cnt_wrap", 64'(RetireCount), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
